// File: rtl/reg_file_mp.sv
// Multi-read-port register file with pending scoreboard, NZP condition codes and a clear sweep.
// Optional read-during-write forwarding is enabled by defining REGF_BYPASS_EN.
module reg_file_mp #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_RD*AW-1:0]    rd_addr_i,
    output logic [NUM_RD*WIDTH-1:0] rd_data_o,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic                    setcc_i,
    output logic [2:0]              cc_nzp_o,
    input  logic                    claim_en_i,
    input  logic [AW-1:0]           claim_addr_i,
    output logic [NUM_REGS-1:0]     pend_o,
    input  logic                    clr_req_i,
    output logic                    clr_busy_o,
    output logic                    clr_done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [2:0]          cc_q, cc_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;

    // Single write port shared by external writes (IDLE) and the sweep (SWEEP).
    logic                wr_act;
    logic [AW-1:0]       wr_a;
    logic [WIDTH-1:0]    wr_v;

    function automatic logic [2:0] nzp_f(input logic [WIDTH-1:0] d);
        return {d[WIDTH-1], d == '0, !d[WIDTH-1] && (d != '0)};
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cc_d    = cc_q;
        pend_d  = pend_q;
        wr_act  = 1'b0;
        wr_a    = '0;
        wr_v    = '0;
        case (state_q)
            S_IDLE: begin
                if (wr_en_i) begin
                    wr_act            = 1'b1;
                    wr_a              = wr_addr_i;
                    wr_v              = wr_data_i;
                    pend_d[wr_addr_i] = 1'b0;
                    if (setcc_i) cc_d = nzp_f(wr_data_i);
                end
                // Claim is applied after the write clear so a same-register claim wins.
                if (claim_en_i) pend_d[claim_addr_i] = 1'b1;
                if (clr_req_i) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                    pend_d  = '0;
                end
            end
            S_SWEEP: begin
                wr_act = 1'b1;
                wr_a   = idx_q;
                wr_v   = '0;
                if (idx_q == AW'(NUM_REGS - 1)) state_d = S_DONE;
                else                            idx_d   = idx_q + AW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cc_q    <= 3'b010;
            pend_q  <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cc_q    <= cc_d;
            pend_q  <= pend_d;
            if (wr_act) regs_q[wr_a] <= wr_v;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr_i[g*AW +: AW];
`ifdef REGF_BYPASS_EN
        assign rd_data_o[g*WIDTH +: WIDTH] = (wr_act && (wr_a == ra)) ? wr_v : regs_q[ra];
`else
        assign rd_data_o[g*WIDTH +: WIDTH] = regs_q[ra];
`endif
    end

    assign cc_nzp_o   = cc_q;
    assign pend_o     = pend_q;
    assign clr_busy_o = (state_q == S_SWEEP);
    assign clr_done_o = (state_q == S_DONE);

endmodule
